// File: rtl/end_keygen_sequencer_if.sv
// Bus between the key sequencer (master) and the e/d key generator (slave).
// The master drives reset/enable/phi; the generator returns a one-cycle e/d result.
interface end_keygen_sequencer_if #(
  parameter int W = 32
);
  logic         kg_rst;
  logic         kg_en;
  logic [W-1:0] kg_phi;
  logic         kg_keys_valid;
  logic [W-1:0] kg_e_key;
  logic [W-1:0] kg_d_key;

  modport master (
    output kg_rst, kg_en, kg_phi,
    input  kg_keys_valid, kg_e_key, kg_d_key
  );

  modport slave (
    input  kg_rst, kg_en, kg_phi,
    output kg_keys_valid, kg_e_key, kg_d_key
  );
endinterface

// File: rtl/end_keygen_sequencer.sv
// Controller for the e/d key generator: flushes, enables, supervises each attempt
// with a timeout and bounded retries, and latches the resulting key pair.
module end_keygen_sequencer #(
  parameter int W            = 32,
  parameter int FLUSH_CYCLES = 4,
  parameter int TIMEOUT      = 65535,
  parameter int MAX_RETRY    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [W-1:0]           phi_in,
  end_keygen_sequencer_if.master kg,
  output logic                   busy,
  output logic                   keys_ready,
  output logic                   error,
  output logic [W-1:0]           e_key,
  output logic [W-1:0]           d_key
);

  localparam int FCW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int RCW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);
  localparam logic [15:0]    TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [RCW-1:0] RETRY_MAX  = RCW'(MAX_RETRY);
  localparam logic [W-1:0]   PHI_MIN    = W'(32'd3);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  state_e         state_r, state_nxt_s;
  logic [FCW-1:0] flush_cnt_r;
  logic [15:0]    timer_r;
  logic [RCW-1:0] retry_cnt_r;
  logic [W-1:0]   kg_phi_r, e_key_r, d_key_r;
  logic           kg_en_r, busy_r, keys_ready_r, error_r;
  logic           load_phi_s, load_keys_s, retry_inc_s, keys_ok_s, attempt_end_s;

  // Next-state decode; abort dominates start and a same-cycle valid.
  always_comb begin
    state_nxt_s   = state_r;
    load_phi_s    = 1'b0;
    load_keys_s   = 1'b0;
    retry_inc_s   = 1'b0;
    keys_ok_s     = kg.kg_keys_valid && (kg.kg_e_key != '0) &&
                    (kg.kg_e_key < kg_phi_r) && (kg.kg_d_key < kg_phi_r);
    // A malformed result ends the attempt exactly like a timeout.
    attempt_end_s = (kg.kg_keys_valid && !keys_ok_s) || (timer_r == TIMER_LAST);
    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start && (phi_in >= PHI_MIN)) begin
            load_phi_s  = 1'b1;
            state_nxt_s = ST_FLUSH;
          end else if (start) begin
            state_nxt_s = ST_ERROR;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_r == FLUSH_LAST) state_nxt_s = ST_RUN;
          else                           state_nxt_s = ST_FLUSH;
        end
        ST_RUN: begin
          if (keys_ok_s) begin
            load_keys_s = 1'b1;
            state_nxt_s = ST_DONE;
          end else if (attempt_end_s && (retry_cnt_r < RETRY_MAX)) begin
            retry_inc_s = 1'b1;
            state_nxt_s = ST_FLUSH;
          end else if (attempt_end_s) begin
            state_nxt_s = ST_ERROR;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State, flush/run timers and retry count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= '0;
      timer_r     <= 16'd0;
      retry_cnt_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_FLUSH) && (state_nxt_s == ST_FLUSH)) flush_cnt_r <= flush_cnt_r + 1'b1;
      else                                                   flush_cnt_r <= '0;
      if ((state_r == ST_RUN) && (state_nxt_s == ST_RUN)) timer_r <= timer_r + 16'd1;
      else                                               timer_r <= 16'd0;
      if (load_phi_s)       retry_cnt_r <= '0;
      else if (retry_inc_s) retry_cnt_r <= retry_cnt_r + 1'b1;
      else                  retry_cnt_r <= retry_cnt_r;
    end
  end

  // Registered outputs decoded from the next state, plus phi/key capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      kg_en_r      <= 1'b0;
      busy_r       <= 1'b0;
      keys_ready_r <= 1'b0;
      error_r      <= 1'b0;
      kg_phi_r     <= '0;
      e_key_r      <= '0;
      d_key_r      <= '0;
    end else begin
      kg_en_r      <= (state_nxt_s == ST_RUN);
      busy_r       <= (state_nxt_s == ST_FLUSH) || (state_nxt_s == ST_RUN);
      keys_ready_r <= (state_nxt_s == ST_DONE);
      error_r      <= (state_nxt_s == ST_ERROR);
      if (load_phi_s) kg_phi_r <= phi_in;
      else            kg_phi_r <= kg_phi_r;
      if (load_keys_s) begin
        e_key_r <= kg.kg_e_key;
        d_key_r <= kg.kg_d_key;
      end else begin
        e_key_r <= e_key_r;
        d_key_r <= d_key_r;
      end
    end
  end

  assign kg.kg_rst   = rst | (state_r == ST_FLUSH);
  assign kg.kg_en    = kg_en_r;
  assign kg.kg_phi   = kg_phi_r;
  assign busy        = busy_r;
  assign keys_ready  = keys_ready_r;
  assign error       = error_r;
  assign e_key       = e_key_r;
  assign d_key       = d_key_r;

endmodule
